// File: rtl/step_seq_pkg.sv
// Shared types for the step-response sequencer: FSM states and edge-history entry.
package step_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Widest timestamp an entry can carry; instances use the low TIME_WIDTH bits.
    localparam int HIST_TW = 64;

    typedef struct packed {
        logic [HIST_TW-1:0] tstamp;
        logic               dir;
    } hist_entry_t;

endpackage

// File: rtl/edge_hist_buf.sv
// Circular edge-history buffer: newest entry overwrites the oldest when full,
// count saturates at DEPTH. Exposes post-write count/newest index so a same-cycle
// evaluation snapshot includes the edge being written.
module edge_hist_buf
    import step_seq_pkg::*;
#(
    parameter  int DEPTH      = 8,
    parameter  int TIME_WIDTH = 32,
    localparam int AW         = $clog2(DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [TIME_WIDTH-1:0] wr_time,
    input  logic                  wr_dir,
    input  logic [AW-1:0]         rd_idx,
    output hist_entry_t           rd_entry,
    output logic [CW-1:0]         count_d,
    output logic [AW-1:0]         newest_d
);

    hist_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q;

    // Next pointer/count; newest index reflects a write happening this cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        newest_d = wr_ptr_q - AW'(1);
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            newest_d = wr_ptr_q;
            if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
        end
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= '{tstamp: HIST_TW'(wr_time), dir: wr_dir};
    end

    assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/step_response_seq.sv
// Step-response sequencer: on request, walks the edge history newest to oldest,
// feeds each time delta to an external PWL evaluator, and sums the returned
// step-response samples signed by edge direction.
module step_response_seq
    import step_seq_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int TIME_WIDTH  = 32,
    parameter int IN_WIDTH    = 24,   // assumed narrower than TIME_WIDTH
    parameter int OUT_WIDTH   = 18,
    parameter int PWL_LATENCY = 1,
    parameter int ACC_WIDTH   = OUT_WIDTH + $clog2(DEPTH) + 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        edge_valid,
    input  logic [TIME_WIDTH-1:0]       edge_time,
    input  logic                        edge_dir,
    input  logic                        eval_start,
    input  logic [TIME_WIDTH-1:0]       eval_time,
    output logic                        busy,
    output logic [IN_WIDTH-1:0]         pwl_in,
    input  logic signed [OUT_WIDTH-1:0] pwl_out,
    output logic signed [ACC_WIDTH-1:0] result,
    output logic                        result_valid,
    output logic                        edge_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (PWL_LATENCY > 1) ? $clog2(PWL_LATENCY) : 1;

    state_e                 state_q;
    logic [TIME_WIDTH-1:0]  eval_time_q;
    logic [AW-1:0]          rd_idx_q;
    logic [CW-1:0]          rem_q;
    logic [DW-1:0]          drain_q;
    logic                   busy_q;
    logic signed [ACC_WIDTH-1:0] result_q;
    logic                   result_valid_q;

    logic                   pend_v_q, pend_v_d;
    logic [TIME_WIDTH-1:0]  pend_t_q, pend_t_d;
    logic                   pend_dir_q, pend_dir_d;
    logic                   ovf_q, ovf_d;

    logic                   buf_wr;
    logic [TIME_WIDTH-1:0]  buf_wr_time;
    logic                   buf_wr_dir;
    hist_entry_t            rd_entry;
    logic [CW-1:0]          count_d;
    logic [AW-1:0]          newest_d;

    logic                   idle, issue;
    logic [TIME_WIDTH-1:0]  delta;
    logic                   delta_neg, delta_over;

    logic [PWL_LATENCY:0]   vld_pipe, dir_pipe;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d, pwl_ext;

    // Timestamp bits above TIME_WIDTH are always zero; fold them into a sink.
    logic unused_ts_hi;
    assign unused_ts_hi = ^rd_entry.tstamp;

    assign idle  = (state_q == IDLE);
    assign issue = (state_q == ISSUE);

    // Buffer write port: a parked edge commits before any fresh one.
    always_comb begin
        buf_wr      = idle && (pend_v_q || edge_valid);
        buf_wr_time = pend_v_q ? pend_t_q   : edge_time;
        buf_wr_dir  = pend_v_q ? pend_dir_q : edge_dir;
    end

    edge_hist_buf #(
        .DEPTH      (DEPTH),
        .TIME_WIDTH (TIME_WIDTH)
    ) u_hist (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (buf_wr),
        .wr_time  (buf_wr_time),
        .wr_dir   (buf_wr_dir),
        .rd_idx   (rd_idx_q),
        .rd_entry (rd_entry),
        .count_d  (count_d),
        .newest_d (newest_d)
    );

    // Single-entry parking slot for edges that arrive while busy; extra ones are dropped.
    always_comb begin
        pend_v_d   = pend_v_q;
        pend_t_d   = pend_t_q;
        pend_dir_d = pend_dir_q;
        ovf_d      = ovf_q;
        if (!idle) begin
            if (edge_valid) begin
                if (pend_v_q) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_v_d   = 1'b1;
                    pend_t_d   = edge_time;
                    pend_dir_d = edge_dir;
                end
            end
        end else if (pend_v_q) begin
            // Parked edge is written this cycle; a concurrent new edge takes its slot.
            pend_v_d   = edge_valid;
            pend_t_d   = edge_time;
            pend_dir_d = edge_dir;
        end
    end

    // Pending-slot and sticky overflow state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q   <= 1'b0;
            pend_t_q   <= '0;
            pend_dir_q <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            pend_v_q   <= pend_v_d;
            pend_t_q   <= pend_t_d;
            pend_dir_q <= pend_dir_d;
            ovf_q      <= ovf_d;
        end
    end

    // Signed delta; negative means the edge lies in the future and contributes nothing.
    always_comb begin
        delta      = eval_time_q - rd_entry.tstamp[TIME_WIDTH-1:0];
        delta_neg  = delta[TIME_WIDTH-1];
        delta_over = |(delta >> IN_WIDTH);
        pwl_in     = '0;
        if (issue && !delta_neg) pwl_in = delta_over ? '1 : delta[IN_WIDTH-1:0];
    end

    // Tag pipeline aligning {valid-and-unmasked, dir} with the PWL output.
    assign vld_pipe[0] = issue && !delta_neg;
    assign dir_pipe[0] = rd_entry.dir;

    generate
        if (PWL_LATENCY > 0) begin : g_tag
            logic [PWL_LATENCY-1:0] vld_sr_q, dir_sr_q;
            assign vld_pipe[PWL_LATENCY:1] = vld_sr_q;
            assign dir_pipe[PWL_LATENCY:1] = dir_sr_q;
            // Shift tags one stage per cycle.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_sr_q <= '0;
                    dir_sr_q <= '0;
                end else begin
                    vld_sr_q <= vld_pipe[PWL_LATENCY-1:0];
                    dir_sr_q <= dir_pipe[PWL_LATENCY-1:0];
                end
            end
        end
    endgenerate

    // Accumulator: cleared on accept, then adds/subtracts each aligned sample.
    always_comb begin
        pwl_ext = {{(ACC_WIDTH-OUT_WIDTH){pwl_out[OUT_WIDTH-1]}}, pwl_out};
        acc_d   = acc_q;
        if (idle && eval_start)           acc_d = '0;
        else if (vld_pipe[PWL_LATENCY])   acc_d = dir_pipe[PWL_LATENCY] ? acc_q + pwl_ext
                                                                        : acc_q - pwl_ext;
    end

    // Accumulator state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

    // Sequencer FSM with registered busy/result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            eval_time_q    <= '0;
            rd_idx_q       <= '0;
            rem_q          <= '0;
            drain_q        <= '0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (eval_start) begin
                        eval_time_q <= eval_time;
                        rd_idx_q    <= newest_d;
                        rem_q       <= count_d - CW'(1);
                        busy_q      <= 1'b1;
                        state_q     <= (count_d != '0) ? ISSUE : DONE;
                    end
                end
                ISSUE: begin
                    rd_idx_q <= rd_idx_q - AW'(1);
                    if (rem_q == '0) begin
                        if (PWL_LATENCY == 0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= DRAIN;
                            drain_q <= DW'(PWL_LATENCY - 1);
                        end
                    end else begin
                        rem_q <= rem_q - CW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) state_q <= DONE;
                    else               drain_q <= drain_q - DW'(1);
                end
                DONE: begin
                    result_q       <= acc_q;
                    result_valid_q <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign result        = result_q;
    assign result_valid  = result_valid_q;
    assign edge_overflow = ovf_q;

endmodule

// File: tb/tb_step_response_seq.sv
// Self-checking bench for step_response_seq with a min(in,1000) PWL model of latency 1.
module tb_step_response_seq;

    logic               clk, rst_n;
    logic               edge_valid, edge_dir, eval_start;
    logic [31:0]        edge_time, eval_time;
    logic               busy, result_valid, edge_overflow;
    logic [23:0]        pwl_in;
    logic signed [17:0] pwl_out;
    logic signed [21:0] result;

    int n_pass = 0;
    int n_total = 0;

    typedef struct { logic [31:0] t; logic d; } ed_t;
    ed_t mq[$];

    step_response_seq dut (
        .clk(clk), .rst_n(rst_n),
        .edge_valid(edge_valid), .edge_time(edge_time), .edge_dir(edge_dir),
        .eval_start(eval_start), .eval_time(eval_time), .busy(busy),
        .pwl_in(pwl_in), .pwl_out(pwl_out),
        .result(result), .result_valid(result_valid), .edge_overflow(edge_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PWL evaluator model: out = min(in, 1000), one cycle latency.
    always @(posedge clk)
        pwl_out <= (pwl_in > 24'd1000) ? 18'sd1000 : $signed({8'd0, pwl_in[9:0]});

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: keep at most 8 newest edges, sum clamped/masked samples.
    function automatic void model_push(input logic [31:0] t, input logic d);
        ed_t e;
        e.t = t; e.d = d;
        mq.push_back(e);
        if (mq.size() > 8) void'(mq.pop_front());
    endfunction

    function automatic longint model_sum(input logic [31:0] et);
        longint s = 0;
        foreach (mq[i]) begin
            logic [31:0] dl;
            longint v;
            dl = et - mq[i].t;
            if (!dl[31]) begin
                v = (dl > 32'h00FF_FFFF) ? 64'h00FF_FFFF : longint'(dl);
                if (v > 1000) v = 1000;
                s = mq[i].d ? s + v : s - v;
            end
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; edge_valid = 1'b0; eval_start = 1'b0;
        edge_time = '0; eval_time = '0; edge_dir = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mq.delete();
    endtask

    task automatic send_edge(input logic [31:0] t, input logic d);
        edge_valid = 1'b1; edge_time = t; edge_dir = d;
        model_push(t, d);
        tick();
        edge_valid = 1'b0;
    endtask

    // Runs one evaluation (optionally with a same-cycle edge) and checks latency/result/pulse.
    task automatic run_eval(input logic [31:0] et, input logic with_edge, input logic [31:0] e_t,
                            input logic e_d, input logic chk_pwl, input logic [23:0] exp_pwl,
                            input string name);
        longint exp_res;
        int exp_lat, c;
        if (with_edge) begin
            edge_valid = 1'b1; edge_time = e_t; edge_dir = e_d;
            model_push(e_t, e_d);
        end
        exp_res = model_sum(et);
        exp_lat = (mq.size() == 0) ? 1 : mq.size() + 2;
        eval_start = 1'b1; eval_time = et;
        tick();
        eval_start = 1'b0; edge_valid = 1'b0;
        if (chk_pwl) begin
            n_total++;
            if (pwl_in !== exp_pwl) $display("FAIL %s pwl_in: got %0h want %0h", name, pwl_in, exp_pwl);
            else n_pass++;
        end
        c = 0;
        while (result_valid !== 1'b1 && c < 50) begin tick(); c++; end
        n_total++;
        if (c != exp_lat) $display("FAIL %s latency: got %0d want %0d", name, c, exp_lat);
        else n_pass++;
        n_total++;
        if (longint'(result) !== exp_res) $display("FAIL %s result: got %0d want %0d", name, result, exp_res);
        else n_pass++;
        tick();
        n_total++;
        if (result_valid !== 1'b0 || longint'(result) !== exp_res)
            $display("FAIL %s pulse/hold: valid %b result %0d want 0/%0d", name, result_valid, result, exp_res);
        else n_pass++;
    endtask

    task automatic test_reset();
        do_reset();
        n_total++;
        if ({busy, result_valid, edge_overflow} !== 3'b000 || result !== '0 || pwl_in !== '0)
            $display("FAIL reset_state: busy %b rv %b ovf %b res %0d pwl %0h want all 0",
                     busy, result_valid, edge_overflow, result, pwl_in);
        else n_pass++;
    endtask

    task automatic test_empty();
        do_reset();
        run_eval(500, 1'b0, 0, 1'b0, 1'b0, '0, "empty");
    endtask

    task automatic test_two_edges();
        do_reset();
        send_edge(100, 1'b1);
        send_edge(300, 1'b0);
        run_eval(1000, 1'b0, 0, 1'b0, 1'b1, 24'd700, "two_edges");
    endtask

    task automatic test_mask_clamp();
        do_reset();
        send_edge(2000, 1'b1);
        run_eval(1000, 1'b0, 0, 1'b0, 1'b1, 24'd0, "mask");
        do_reset();
        send_edge(0, 1'b1);
        run_eval(32'h4000_0000, 1'b0, 0, 1'b0, 1'b1, 24'hFF_FFFF, "clamp");
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 10; i++) send_edge(i, 1'b1);
        run_eval(20, 1'b0, 0, 1'b0, 1'b1, 24'd10, "wrap");
    endtask

    task automatic test_same_cycle();
        do_reset();
        send_edge(400, 1'b1);
        run_eval(1000, 1'b1, 700, 1'b0, 1'b1, 24'd300, "same_cycle");
    endtask

    task automatic test_busy_edges();
        int c;
        do_reset();
        send_edge(100, 1'b1);
        eval_start = 1'b1; eval_time = 1000;
        tick();
        eval_start = 1'b0;
        n_total++;
        if (busy !== 1'b1) $display("FAIL busy_flag: got %b want 1", busy);
        else n_pass++;
        edge_valid = 1'b1; edge_time = 200; edge_dir = 1'b1;
        tick();
        edge_time = 300;
        tick();
        edge_valid = 1'b0;
        c = 2;
        while (result_valid !== 1'b1 && c < 50) begin tick(); c++; end
        n_total++;
        if (c != 3 || result !== 22'sd900) $display("FAIL busy_eval: lat %0d res %0d want 3/900", c, result);
        else n_pass++;
        n_total++;
        if (edge_overflow !== 1'b1) $display("FAIL overflow_set: got %b want 1", edge_overflow);
        else n_pass++;
        model_push(200, 1'b1);
        tick();
        run_eval(1000, 1'b0, 0, 1'b0, 1'b0, '0, "pending_commit");
        n_total++;
        if (edge_overflow !== 1'b1) $display("FAIL overflow_sticky: got %b want 1", edge_overflow);
        else n_pass++;
        do_reset();
        n_total++;
        if (edge_overflow !== 1'b0) $display("FAIL overflow_clear: got %b want 0", edge_overflow);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        do_reset();
        send_edge(100, 1'b1);
        send_edge(300, 1'b0);
        eval_start = 1'b1; eval_time = 1000;
        tick();
        eval_start = 1'b0;
        rst_n = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b want 0", busy);
        else n_pass++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mq.delete();
        for (int i = 0; i < 6; i++) begin
            if (result_valid === 1'b1) pulses++;
            tick();
        end
        n_total++;
        if (pulses != 0 || busy !== 1'b0) $display("FAIL reset_mid_abort: pulses %0d busy %b want 0/0", pulses, busy);
        else n_pass++;
        run_eval(1000, 1'b0, 0, 1'b0, 1'b0, '0, "after_reset");
    endtask

    task automatic test_random();
        for (int it = 0; it < 25; it++) begin
            int ne;
            logic [31:0] et;
            if ($urandom_range(0, 3) == 0) do_reset();
            ne = $urandom_range(0, 11);
            for (int k = 0; k < ne; k++) send_edge($urandom_range(0, 3000), 1'($urandom_range(0, 1)));
            et = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 3000);
            run_eval(et, 1'($urandom_range(0, 1)), $urandom_range(0, 3000),
                     1'($urandom_range(0, 1)), 1'b0, '0, $sformatf("random%0d", it));
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    initial begin
        test_reset();
        test_empty();
        test_two_edges();
        test_mask_clamp();
        test_wrap();
        test_same_cycle();
        test_busy_edges();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
